// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port pixel RAM arbiter. Scanout reads always win; the
// clear sequencer and the host write port share the blanking cycles.
module fb_arbiter #(
    parameter int unsigned A        = 20,
    parameter int unsigned D        = 12,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic         clk_d,
    input  logic         rst_n,
    input  logic         video_on,
    input  logic [9:0]   x_loc,
    input  logic [9:0]   y_loc,
    output logic [D-1:0] rd_pixel,
    output logic         rd_valid,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [9:0]   wr_x,
    input  logic [9:0]   wr_y,
    input  logic [D-1:0] wr_data,
    output logic         wr_err,
    input  logic         clear_req,
    input  logic [D-1:0] clear_color,
    output logic         clear_busy,
    output logic         clear_done,
    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_din,
    output logic         ram_we,
    input  logic [D-1:0] ram_dout
);
    localparam logic [9:0]  H_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
    localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t       state, state_nx;
    logic [9:0]   cx, cy, cx_nx, cy_nx;
    logic [D-1:0] clr_color, clr_color_nx;
    logic [A-1:0] addr_nx;
    logic [D-1:0] din_nx;
    logic         we_nx, err_nx, done_nx;
    logic         vid_d1, vid_d2;
    logic         wr_in_range;

    assign clear_busy  = (state == CLEAR);
    assign wr_ready    = rst_n & ~video_on & ~clear_busy;
    assign wr_in_range = ({1'b0, wr_x} < H_LIM) && ({1'b0, wr_y} < V_LIM);

    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cx        <= '0;
            cy        <= '0;
            clr_color <= '0;
        end else begin
            state     <= state_nx;
            cx        <= cx_nx;
            cy        <= cy_nx;
            clr_color <= clr_color_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cx_nx        = cx;
        cy_nx        = cy;
        clr_color_nx = clr_color;
        addr_nx      = ram_addr;
        din_nx       = ram_din;
        we_nx        = 1'b0;
        err_nx       = 1'b0;
        done_nx      = 1'b0;

        if (video_on) begin
            addr_nx = {x_loc, y_loc};
        end else if (state == CLEAR) begin
            addr_nx = {cx, cy};
            din_nx  = clr_color;
            we_nx   = 1'b1;
            if (cx == H_LAST) begin
                cx_nx = '0;
                if (cy == V_LAST) begin
                    cy_nx    = '0;
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    cy_nx = cy + 10'd1;
                end
            end else begin
                cx_nx = cx + 10'd1;
            end
        end else if (wr_valid) begin
            if (wr_in_range) begin
                addr_nx = {wr_x, wr_y};
                din_nx  = wr_data;
                we_nx   = 1'b1;
            end else begin
                err_nx = 1'b1;
            end
        end

        // A same-cycle host write is still served above; the clear takes over next cycle.
        if ((state == IDLE) && clear_req) begin
            state_nx     = CLEAR;
            clr_color_nx = clear_color;
            cx_nx        = '0;
            cy_nx        = '0;
        end
    end

    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr   <= '0;
            ram_din    <= '0;
            ram_we     <= 1'b0;
            wr_err     <= 1'b0;
            clear_done <= 1'b0;
            vid_d1     <= 1'b0;
            vid_d2     <= 1'b0;
            rd_valid   <= 1'b0;
            rd_pixel   <= '0;
        end else begin
            ram_addr   <= addr_nx;
            ram_din    <= din_nx;
            ram_we     <= we_nx;
            wr_err     <= err_nx;
            clear_done <= done_nx;
            vid_d1     <= video_on;
            vid_d2     <= vid_d1;
            rd_valid   <= vid_d2;
            rd_pixel   <= vid_d2 ? ram_dout : '0;
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: randomized scoreboard bench for fb_arbiter on a reduced
// 40x30 screen, with a pixel-array reference model and a behavioural RAM.
module tb_fb_arbiter;
    localparam int unsigned A = 20;
    localparam int unsigned D = 12;
    localparam int unsigned H = 40;
    localparam int unsigned V = 30;

    logic         clk_d       = 1'b0;
    logic         rst_n       = 1'b1;
    logic         video_on    = 1'b0;
    logic [9:0]   x_loc       = '0;
    logic [9:0]   y_loc       = '0;
    logic [D-1:0] rd_pixel;
    logic         rd_valid;
    logic         wr_valid    = 1'b0;
    logic         wr_ready;
    logic [9:0]   wr_x        = '0;
    logic [9:0]   wr_y        = '0;
    logic [D-1:0] wr_data     = '0;
    logic         wr_err;
    logic         clear_req   = 1'b0;
    logic [D-1:0] clear_color = '0;
    logic         clear_busy;
    logic         clear_done;
    logic [A-1:0] ram_addr;
    logic [D-1:0] ram_din;
    logic         ram_we;
    logic [D-1:0] ram_dout    = '0;

    always #5 clk_d = ~clk_d;

    fb_arbiter #(.A(A), .D(D), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk_d(clk_d), .rst_n(rst_n), .video_on(video_on), .x_loc(x_loc), .y_loc(y_loc),
        .rd_pixel(rd_pixel), .rd_valid(rd_valid), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_err(wr_err),
        .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
        .clear_done(clear_done), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout)
    );

    // Synchronous RAM: read-before-write, data out one cycle after the address.
    logic [D-1:0] ram_mem [int unsigned];
    always @(posedge clk_d) begin : ram_model
        logic [D-1:0] q;
        q = ram_mem.exists(32'(ram_addr)) ? ram_mem[32'(ram_addr)] : '0;
        if (ram_we) ram_mem[32'(ram_addr)] = ram_din;
        ram_dout <= q;
    end

    int unsigned cyc = 0;
    always @(posedge clk_d) cyc <= cyc + 1;

    typedef struct {
        int unsigned  due;
        logic [A-1:0] addr;
        logic [D-1:0] data;
    } ev_t;

    ev_t         q_rd[$];
    ev_t         q_wr[$];
    int unsigned q_err[$];
    int unsigned q_done[$];

    logic [D-1:0] ref_mem [int unsigned];
    logic         m_busy  = 1'b0;
    int unsigned  m_k     = 0;
    logic [D-1:0] m_color = '0;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned busy_cycles = 0;
    int unsigned blank_busy = 0;
    int unsigned done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int unsigned key(input logic [9:0] x, input logic [9:0] y);
        return {12'd0, x, y};
    endfunction

    function automatic logic [D-1:0] mem_get(input logic [9:0] x, input logic [9:0] y);
        return ref_mem.exists(key(x, y)) ? ref_mem[key(x, y)] : '0;
    endfunction

    function automatic logic [9:0] rnd_x();
        return 10'($urandom_range(H - 1, 0));
    endfunction
    function automatic logic [9:0] rnd_y();
        return 10'($urandom_range(V - 1, 0));
    endfunction
    function automatic logic [D-1:0] rnd_d();
        return D'($urandom);
    endfunction
    function automatic logic rnd_bit();
        return 1'($urandom_range(1, 0));
    endfunction

    ev_t me;
    int unsigned mt;
    always @(negedge clk_d) begin
        if (rd_valid) begin
            chk("rd_expected", 32'(q_rd.size() != 0), 32'd1);
            if (q_rd.size() != 0) begin
                me = q_rd.pop_front();
                chk("rd_latency", cyc, me.due);
                chk("rd_pixel", 32'(rd_pixel), 32'(me.data));
            end
        end else begin
            chk("rd_pixel_idle", 32'(rd_pixel), 32'd0);
        end
        if (ram_we) begin
            chk("ram_we_expected", 32'(q_wr.size() != 0), 32'd1);
            if (q_wr.size() != 0) begin
                me = q_wr.pop_front();
                chk("ram_we_cycle", cyc, me.due);
                chk("ram_addr", 32'(ram_addr), 32'(me.addr));
                chk("ram_din", 32'(ram_din), 32'(me.data));
            end
        end
        if (wr_err) begin
            chk("wr_err_expected", 32'(q_err.size() != 0), 32'd1);
            if (q_err.size() != 0) begin
                mt = q_err.pop_front();
                chk("wr_err_cycle", cyc, mt);
            end
        end
        if (clear_done) begin
            done_cnt++;
            chk("clear_done_expected", 32'(q_done.size() != 0), 32'd1);
            if (q_done.size() != 0) begin
                mt = q_done.pop_front();
                chk("clear_done_cycle", cyc, mt);
            end
        end
    end

    // Apply one cycle of inputs and advance the reference model by the grant rules.
    task automatic drive(input logic vo, input logic [9:0] x, input logic [9:0] y,
                         input logic wv, input logic [9:0] wx, input logic [9:0] wy,
                         input logic [D-1:0] wd, input logic cr, input logic [D-1:0] cc);
        ev_t         e;
        int unsigned due;
        logic        busy0;
        @(posedge clk_d);
        #2;
        video_on = vo;  x_loc = x;  y_loc = y;
        wr_valid = wv;  wr_x = wx;  wr_y = wy;  wr_data = wd;
        clear_req = cr; clear_color = cc;
        #1;
        chk("wr_ready", 32'(wr_ready), 32'(!vo && !m_busy));
        chk("clear_busy", 32'(clear_busy), 32'(m_busy));
        if (clear_busy) busy_cycles++;
        if (clear_busy && !vo) blank_busy++;
        due   = cyc + 1;
        busy0 = m_busy;
        if (vo) begin
            e.due = due + 2; e.addr = {x, y}; e.data = mem_get(x, y);
            q_rd.push_back(e);
        end else if (m_busy) begin
            e.due  = due;
            e.addr = {10'(m_k % H), 10'(m_k / H)};
            e.data = m_color;
            ref_mem[32'(e.addr)] = m_color;
            q_wr.push_back(e);
            m_k++;
            if (m_k == H * V) begin
                m_busy = 1'b0;
                q_done.push_back(due);
            end
        end else if (wv) begin
            if ((32'(wx) < H) && (32'(wy) < V)) begin
                e.due = due; e.addr = {wx, wy}; e.data = wd;
                ref_mem[key(wx, wy)] = wd;
                q_wr.push_back(e);
            end else begin
                q_err.push_back(due);
            end
        end
        if (!busy0 && cr) begin
            m_busy  = 1'b1;
            m_k     = 0;
            m_color = cc;
        end
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic blank_rand();
        drive(1'b0, rnd_x(), rnd_y(), rnd_bit(), rnd_x(), rnd_y(), rnd_d(), rnd_bit(), rnd_d());
    endtask

    task automatic read_px(input logic [9:0] x, input logic [9:0] y);
        drive(1'b1, x, y, rnd_bit(), rnd_x(), rnd_y(), rnd_d(), 1'b0, '0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_rd_pixel", 32'(rd_pixel), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        chk("rst_clear_busy", 32'(clear_busy), 32'd0);
        chk("rst_clear_done", 32'(clear_done), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    endtask

    task automatic do_reset(input int unsigned n);
        @(posedge clk_d);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        q_rd.delete(); q_wr.delete(); q_err.delete(); q_done.delete();
        m_busy = 1'b0;
        m_k    = 0;
        repeat (n) begin
            @(posedge clk_d);
            #2;
            video_on = rnd_bit(); x_loc = rnd_x(); y_loc = rnd_y();
            wr_valid = rnd_bit(); wr_x = rnd_x(); wr_y = rnd_y(); wr_data = rnd_d();
            clear_req = rnd_bit(); clear_color = rnd_d();
            #1;
            check_reset_outputs();
        end
        @(posedge clk_d);
        #2;
        video_on = 1'b0; wr_valid = 1'b0; clear_req = 1'b0;
        rst_n = 1'b1;
    endtask

    int unsigned done_base;

    initial begin
        #1 rst_n = 1'b0;
        do_reset(5);

        // Host write then scan, including a read right after the write.
        drive(1'b0, '0, '0, 1'b1, 10'd10, 10'd20, 12'hF0A, 1'b0, '0);
        read_px(10'd10, 10'd20);
        read_px(10'd11, 10'd20);
        idle();
        read_px(10'd10, 10'd20);

        // Out-of-range writes are accepted, dropped and flagged.
        drive(1'b0, '0, '0, 1'b1, 10'd640, 10'd5, 12'h777, 1'b0, '0);
        drive(1'b0, '0, '0, 1'b1, 10'(H), 10'd5, 12'h778, 1'b0, '0);
        idle();
        drive(1'b0, '0, '0, 1'b1, 10'd5, 10'(V), 12'h779, 1'b0, '0);
        read_px(10'(H - 1), 10'd5);
        read_px(10'd5, 10'(V - 1));

        // Host request held across a video_on rise.
        drive(1'b1, 10'd3, 10'd3, 1'b1, 10'd3, 10'd3, 12'hABC, 1'b0, '0);
        drive(1'b0, '0, '0, 1'b1, 10'd3, 10'd3, 12'hABC, 1'b0, '0);
        read_px(10'd3, 10'd3);

        // Full clear in blanking; the host write in the start cycle is still taken.
        busy_cycles = 0;
        done_base   = done_cnt;
        drive(1'b0, '0, '0, 1'b1, 10'd1, 10'd1, 12'h123, 1'b1, 12'h00F);
        for (int i = 0; i < int'(H * V) + 8 && m_busy; i++) blank_rand();
        idle();
        idle();
        chk("clear1_busy_cycles", busy_cycles, H * V);
        chk("clear1_done_pulses", done_cnt - done_base, 32'd1);
        for (int y = 0; y < int'(V); y++)
            for (int x = 0; x < int'(H); x++)
                read_px(10'(x), 10'(y));

        // Clear interleaved with scanout at 50% duty.
        blank_busy = 0;
        done_base  = done_cnt;
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1, rnd_d());
        for (int i = 0; i < int'(2 * H * V) + 8 && m_busy; i++)
            drive(i[0], rnd_x(), rnd_y(), rnd_bit(), rnd_x(), rnd_y(), rnd_d(), rnd_bit(), rnd_d());
        idle();
        idle();
        chk("clear2_blank_cycles", blank_busy, H * V);
        chk("clear2_done_pulses", done_cnt - done_base, 32'd1);
        repeat (100) read_px(rnd_x(), rnd_y());

        // Random mix of scanout, host writes (some out of range) and rare clears.
        for (int i = 0; i < 2500; i++)
            drive(rnd_bit(), rnd_x(), rnd_y(), ($urandom_range(9, 0) < 6),
                  10'($urandom_range(H + 2, 0)), 10'($urandom_range(V + 2, 0)), rnd_d(),
                  ($urandom_range(399, 0) == 0), rnd_d());
        for (int i = 0; i < int'(2 * H * V) && m_busy; i++) blank_rand();
        idle();
        chk("random_clear_finished", 32'(clear_busy), 32'd0);
        repeat (200) read_px(rnd_x(), rnd_y());

        // Reset in the middle of a clear, then restart from the origin.
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1, 12'h5A5);
        for (int i = 0; i < int'(H * V) && m_k < 3 * H + 10; i++)
            drive(1'b0, rnd_x(), rnd_y(), 1'b0, '0, '0, '0, 1'b0, '0);
        read_px(10'd0, 10'd0);
        do_reset(3);
        read_px(10'd9, 10'd3);
        read_px(10'd10, 10'd3);
        read_px(10'd11, 10'd3);
        read_px(10'd0, 10'd4);
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1, 12'h0C3);
        for (int i = 0; i < int'(H * V) + 8 && m_busy; i++) blank_rand();

        repeat (4) idle();
        @(negedge clk_d);
        #1;
        chk("rd_queue_drained", 32'(q_rd.size()), 32'd0);
        chk("wr_queue_drained", 32'(q_wr.size()), 32'd0);
        chk("err_queue_drained", 32'(q_err.size()), 32'd0);
        chk("done_queue_drained", 32'(q_done.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Single-port frame-buffer access controller sitting between the 640x480 VGA scanout path and the 2^20 x 12-bit synchronous pixel RAM. Each cycle it grants exactly one RAM access: display reads during active video, otherwise a built-in full-screen clear sequencer or an external host pixel-write port. It replaces the ad-hoc RAM initialisation path with a deterministic, handshaked write path while keeping scanout latency fixed.

## Interface

- A, 20, RAM address bits; address is {x[9:0], y[9:0]}
- D, 12, pixel width, packed {R[11:8], G[7:4], B[3:0]}
- H_ACTIVE, 640, visible columns
- V_ACTIVE, 480, visible rows

Ports:

- clk_d  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- video_on  in  1  scanout in active region
- x_loc  in  10  scanout column
- y_loc  in  10  scanout row
- rd_pixel  out  D  scanout pixel; 0 when rd_valid=0
- rd_valid  out  1  rd_pixel corresponds to a sampled active-region location
- wr_valid  in  1  host write request
- wr_ready  out  1  host write accepted this cycle when wr_valid=1
- wr_x  in  10  host write column
- wr_y  in  10  host write row
- wr_data  in  D  host write pixel
- wr_err  out  1  one-cycle pulse: accepted write was out of range and dropped
- clear_req  in  1  start full-screen clear
- clear_color  in  D  fill value, latched at clear start
- clear_busy  out  1  clear sequence in progress
- clear_done  out  1  one-cycle pulse after last clear write issued
- ram_addr  out  A  RAM address (registered)
- ram_din  out  D  RAM write data (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_dout  in  D  RAM read data (valid one cycle after ram_addr)

## Operation

- Grant priority per cycle: (1) display read if video_on=1; (2) clear write if clear_busy=1; (3) host write if wr_valid=1; else idle (ram_we=0, ram_addr holds).
- Display read: ram_addr <= {x_loc, y_loc}, ram_we <= 0.
- wr_ready = rst_n & ~video_on & ~clear_busy (combinational). Write accepted on wr_valid & wr_ready. In-range (wr_x < H_ACTIVE and wr_y < V_ACTIVE) -> ram_addr <= {wr_x, wr_y}, ram_din <= wr_data, ram_we <= 1. Out-of-range -> ram_we <= 0, wr_err pulses next cycle.
- Clear FSM states IDLE, CLEAR.
  - IDLE -> CLEAR when clear_req=1; latch clear_color; cx=0, cy=0. clear_busy=1 from next cycle.
  - CLEAR: on each granted cycle (video_on=0) write {cx,cy} with latched color; cx increments, wraps at H_ACTIVE-1 to 0 with cy+1. Cycles with video_on=1 stall cx/cy.
  - Write of (H_ACTIVE-1, V_ACTIVE-1) -> IDLE; clear_done pulses same cycle ram_we for that pixel is asserted.
  - clear_req while in CLEAR is ignored; clear_req and wr_valid in the same IDLE cycle: host write is accepted (wr_ready=1 that cycle), clear starts, later writes blocked.
- Total clear = H_ACTIVE*V_ACTIVE = 307200 granted writes.

## Timing

- Reset (async, rst_n=0): ram_addr=0, ram_din=0, ram_we=0, rd_pixel=0, rd_valid=0, wr_err=0, clear_busy=0, clear_done=0, FSM=IDLE, cx=cy=0. Reset during CLEAR aborts; no further clear writes.
- Scanout latency: x_loc/y_loc/video_on sampled at edge N -> ram_addr at N -> ram_dout at N+1 -> rd_pixel/rd_valid registered at N+2. Fixed 2-cycle latency; rd_valid is video_on delayed 2 cycles.
- Host write: accepted at edge N -> ram_we=1 during cycle N..N+1, RAM updated at edge N+1. wr_err asserted in cycle after acceptance for one cycle.
- Read-after-write to same address in blanking followed by active: new value visible (RAM write completes before any following read edge).
- video_on rising during a pending host request: wr_ready drops same cycle; request must be held by host.

## Test plan

- Reset: hold rst_n=0 with all inputs toggling -> every output 0, wr_ready=0; release -> wr_ready=1 when video_on=0.
- Host write (10,20)=0xF0A in blanking, then scan to (10,20) with video_on=1 -> rd_pixel=0xF0A, rd_valid=1 exactly 2 cycles after x_loc=10,y_loc=20.
- Host write (640,5) -> wr_ready=1, ram_we stays 0, wr_err pulses once; RAM contents unchanged.
- clear_req with clear_color=0x00F, video_on=0 throughout -> clear_busy high for 307200 cycles, clear_done one pulse, every scanned pixel reads 0x00F; wr_ready=0 while busy.
- Clear with video_on 50% duty -> cx/cy stall on active cycles, scanout reads uninterrupted with 2-cycle latency, completion after exactly 307200 blank cycles.
- Assert rst_n=0 mid-clear at pixel (100,3) -> clear_busy=0 immediately, ram_we=0, no further writes; new clear_req after release restarts from (0,0).
